seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 12, SHALL set the per-digit ON phase length to 2^SCAN_DIV CLK cycles.
REQ-002 Parameter BLANK_CYCLES, default 16 (minimum 1), SHALL set the all-off inter-digit gap in CLK cycles.
REQ-003 CLK  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 value  input  16  unsigned binary number to display.
REQ-006 dp_mask  input  4  decimal point per digit, bit i belongs to digit i; captured together with value.
REQ-007 load_valid  input  1  producer offers value/dp_mask.
REQ-008 load_ready  output  1  block can accept a load.
REQ-009 seg_n  output  8  active-low segments {h(dp),g,f,e,d,c,b,a}.
REQ-010 dig_en  output  4  active-high one-hot digit enable; bit 0 = thousands (leftmost), bit 3 = units.

Function
REQ-011 A load SHALL be accepted on a rising edge where load_valid=1 and load_ready=1; value and dp_mask are latched at that edge.
REQ-012 load_ready SHALL be 1 only in IDLE; it falls on the accepting edge and stays 0 through CONVERT and COMMIT.
REQ-013 The converter FSM SHALL have states IDLE -> CONVERT (exactly 16 cycles, one shift-add-3 double-dabble step per cycle) -> COMMIT (1 cycle) -> IDLE.
REQ-014 Latency: a load accepted at edge N SHALL update the display register and reassert load_ready at edge N+17.
REQ-015 The display register SHALL update atomically in COMMIT; no partially converted digit ever reaches seg_n.
REQ-016 If the latched value > 9999, COMMIT SHALL store "dash" for all four digits (segment g only), with dp forced off.
REQ-017 load_valid during CONVERT or COMMIT SHALL be ignored; no queueing.
REQ-018 The scan FSM SHALL repeat per digit: ON phase (2^SCAN_DIV cycles, dig_en one-hot at current index), then BLANK phase (BLANK_CYCLES cycles, dig_en=0, seg_n=8'hFF).
REQ-019 The digit index SHALL advance 0->1->2->3->0 at the end of each BLANK phase, with wrap-around from 3 to 0.
REQ-020 Scan timing SHALL be independent of loads; a COMMIT mid-ON-phase takes effect on the next cycle's seg_n without altering the phase counter.
REQ-021 During ON, seg_n[6:0] SHALL be the inverse of the standard a..g pattern for the stored digit (0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, dash=0x40); seg_n[7] SHALL be ~dp_mask[index].
REQ-022 seg_n and dig_en SHALL be registered outputs, never combinational from inputs.

Reset
REQ-023 While RST=1: dig_en=4'b0000, seg_n=8'hFF, load_ready=0, converter in IDLE, scan index 0, phase counter 0, display register = digits 0,0,0,0 with dp_mask 0.
REQ-024 The first cycle after RST deasserts SHALL start the ON phase of digit 0, with load_ready=1.
REQ-025 RST asserted mid-CONVERT SHALL abort the conversion; nothing is committed.

Configuration
REQ-026 With LEADING_ZERO_BLANK_EN defined, leading zero digits (indices 0..2, left of the first non-zero digit) SHALL show seg_n[6:0]=7'h7F, while dp remains honoured; the units digit is never blanked.
REQ-027 Without LEADING_ZERO_BLANK_EN, all four digits SHALL always be displayed; dash display is unaffected by the macro.

Verification (bench: SCAN_DIV=2, BLANK_CYCLES=1)
REQ-028 Reset release -> digit 0 ON for 4 cycles, seg_n=8'hC0, then 1 cycle of dig_en=0 and seg_n=FF; digit 1 follows; order wraps 3->0.
REQ-029 Load value=1234, dp_mask=4'b0100 at edge N -> load_ready=0 at edges N..N+16, =1 at N+17; digits then show 0xF9, 0xA4, 0x30 (dp on, digit 2), 0x99.
REQ-030 Load value=10000 -> every ON phase shows seg_n=8'hBF; load 9999 -> every ON phase shows 8'h90.
REQ-031 Hold load_valid=1 with a changing value during CONVERT -> only the first value is displayed; second accepted only after load_ready=1.
REQ-032 Assert RST at CONVERT cycle 8 of value=4321 -> outputs return to reset values; after release, display shows 0000, not 4321.
REQ-033 With LEADING_ZERO_BLANK_EN, load value=7 -> digits 0..2 show seg_n=8'hFF; digit 3 shows 8'hF8. Load value=0 -> only the units digit shows 8'hC0.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 4-digit multiplexed 7-segment driver with a serial double-dabble converter.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_scan_ctrl #(
  parameter int SCAN_DIV     = 12,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [7:0]  seg_n,
  output logic [3:0]  dig_en
);
  localparam int BW = $clog2(BLANK_CYCLES + 1);
  localparam int CW = (SCAN_DIV + 1 > BW) ? SCAN_DIV + 1 : BW;
  localparam logic [CW-1:0] ON_LAST = CW'((2 ** SCAN_DIV) - 1);
  localparam logic [CW-1:0] BL_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [3:0] DASH = 4'hA;
  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} cst_t;
  cst_t st_q, st_d;
  logic [31:0] sh_q, sh_d;
  logic [3:0] cnt_q, cnt_d, ldp_q, ldp_d, ddp_q, ddp_d, den_q, den_d;
  logic big_q, big_d, ready_q, ready_d, on_q, on_d, ph_last, lz;
  logic [15:0] disp_q, disp_d, adj;
  logic [1:0] idx_q, idx_d;
  logic [CW-1:0] ph_q, ph_d;
  logic [7:0] seg_q, seg_d;
  logic [3:0] cur;
  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0: seg_pat = 7'h3F;
      4'd1: seg_pat = 7'h06;
      4'd2: seg_pat = 7'h5B;
      4'd3: seg_pat = 7'h4F;
      4'd4: seg_pat = 7'h66;
      4'd5: seg_pat = 7'h6D;
      4'd6: seg_pat = 7'h7D;
      4'd7: seg_pat = 7'h07;
      4'd8: seg_pat = 7'h7F;
      4'd9: seg_pat = 7'h6F;
      default: seg_pat = 7'h40;
    endcase
  endfunction
  // BCD nibbles >= 5 get +3 before each left shift
  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign adj[i*4 +: 4] = (sh_q[16+i*4 +: 4] >= 4'd5) ? sh_q[16+i*4 +: 4] + 4'd3 : sh_q[16+i*4 +: 4];
  end
`ifdef LEADING_ZERO_BLANK_EN
  assign lz = (idx_q == 2'd0 && disp_q[15:12] == 4'd0) || (idx_q == 2'd1 && disp_q[15:8] == 8'd0) ||
              (idx_q == 2'd2 && disp_q[15:4] == 12'd0);
`else
  assign lz = 1'b0;
`endif
  always_comb begin
    st_d = st_q;
    sh_d = sh_q;
    cnt_d = cnt_q;
    big_d = big_q;
    ldp_d = ldp_q;
    disp_d = disp_q;
    ddp_d = ddp_q;
    case (st_q)
      IDLE: if (load_valid && ready_q) begin
        st_d = CONVERT;
        sh_d = {16'h0, value};
        cnt_d = 4'd0;
        big_d = value > 16'd9999;
        ldp_d = dp_mask;
      end
      CONVERT: begin
        sh_d = {adj, sh_q[15:0]} << 1;
        cnt_d = cnt_q + 4'd1;
        st_d = (cnt_q == 4'd15) ? COMMIT : CONVERT;
      end
      COMMIT: begin
        st_d = IDLE;
        disp_d = big_q ? {4{DASH}} : sh_q[31:16];
        ddp_d = big_q ? 4'd0 : ldp_q;
      end
      default: st_d = IDLE;
    endcase
    ready_d = st_d == IDLE;
  end
  // Scan timing free-runs; the display register is only sampled here
  always_comb begin
    ph_last = ph_q == (on_q ? ON_LAST : BL_LAST);
    on_d = on_q ^ ph_last;
    ph_d = ph_last ? '0 : ph_q + CW'(1);
    idx_d = idx_q + {1'b0, !on_q && ph_last};
    cur = disp_q[{~idx_q, 2'b00} +: 4];
    seg_d = on_q ? {~ddp_q[idx_q], lz ? 7'h7F : ~seg_pat(cur)} : 8'hFF;
    den_d = on_q ? 4'b0001 << idx_q : 4'b0000;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q <= IDLE;
      sh_q <= '0;
      cnt_q <= '0;
      big_q <= 1'b0;
      ldp_q <= '0;
      disp_q <= '0;
      ddp_q <= '0;
      ready_q <= 1'b0;
      on_q <= 1'b1;
      idx_q <= '0;
      ph_q <= '0;
      seg_q <= 8'hFF;
      den_q <= '0;
    end else begin
      st_q <= st_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      big_q <= big_d;
      ldp_q <= ldp_d;
      disp_q <= disp_d;
      ddp_q <= ddp_d;
      ready_q <= ready_d;
      on_q <= on_d;
      idx_q <= idx_d;
      ph_q <= ph_d;
      seg_q <= seg_d;
      den_q <= den_d;
    end
  end
  assign load_ready = ready_q;
  assign seg_n = seg_q;
  assign dig_en = den_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: randomized bench for seg7_scan_ctrl against a cycle-level behavioural model.
module tb_seg7_scan_ctrl;
  localparam int ON = 4, BLANK = 1, PER = ON + BLANK;
  localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] FIRST_SEG = 8'hFF;
`else
  localparam logic [7:0] FIRST_SEG = 8'hC0;
`endif
  logic clk = 0, rst = 1, load_valid = 0, load_ready;
  logic [15:0] value = 0;
  logic [3:0] dp_mask = 0, dig_en;
  logic [7:0] seg_n;
  int checks = 0, failures = 0;
  logic [3:0] e_dig, m_dp, p_dp;
  logic [7:0] e_seg;
  logic e_ready;
  int m_t, busy, m_val, p_val;

  seg7_scan_ctrl #(.SCAN_DIV(2), .BLANK_CYCLES(1)) dut (
    .CLK(clk), .RST(rst), .value(value), .dp_mask(dp_mask), .load_valid(load_valid),
    .load_ready(load_ready), .seg_n(seg_n), .dig_en(dig_en));

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_seg(input int v, input logic [3:0] dp, input int d);
    logic [6:0] p;
    if (v > 9999) return 8'hBF;
    p = PAT[(v / (10 ** (3 - d))) % 10];
`ifdef LEADING_ZERO_BLANK_EN
    if (d < 3 && v < 10 ** (3 - d)) p = 7'h00;
`endif
    return {~dp[d], ~p};
  endfunction

  // Reference: expected outputs after each edge, from elapsed time and accepted loads
  always @(posedge clk) begin
    if (rst) begin
      e_dig = 0; e_seg = 8'hFF; e_ready = 0; m_t = 0; busy = 0; m_val = 0; m_dp = 0;
    end else begin
      e_dig = (m_t % PER < ON) ? 4'(1 << ((m_t / PER) % 4)) : 4'd0;
      e_seg = (m_t % PER < ON) ? exp_seg(m_val, m_dp, (m_t / PER) % 4) : 8'hFF;
      m_t++;
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin m_val = p_val; m_dp = p_dp; e_ready = 1; end
      end else if (e_ready && load_valid) begin
        p_val = int'(value); p_dp = dp_mask; busy = 17; e_ready = 0;
      end else e_ready = 1;
    end
  end

  task automatic drive_load(input logic [15:0] v, input logic [3:0] dp);
    int k = 0;
    while (!e_ready && k < 40) begin @(negedge clk); k++; end
    if (!e_ready) begin
      checks++; failures++;
      $display("FAIL load_wait: model never became ready for value %0d", v);
    end
    value = v; dp_mask = dp; load_valid = 1;
    @(negedge clk);
    load_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1; load_valid = 0;
    repeat (3) begin
      @(negedge clk); checks++;
      if (dig_en !== 4'd0 || seg_n !== 8'hFF || load_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: dig_en=%b seg_n=%h ready=%b want 0000 ff 0", dig_en, seg_n, load_ready);
      end
    end
    rst = 0;
    @(negedge clk); checks++;
    if (dig_en !== 4'b0001 || seg_n !== FIRST_SEG || load_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: dig_en=%b seg_n=%h ready=%b want 0001 %h 1", dig_en, seg_n, load_ready, FIRST_SEG);
    end
    for (int i = 1; i < 25; i++) begin
      @(negedge clk); checks++;
      if (dig_en !== ((i % PER < ON) ? 4'(1 << ((i / PER) % 4)) : 4'd0) || seg_n !== e_seg) begin
        failures++;
        $display("FAIL scan_order cyc %0d: dig_en=%b seg_n=%h want %b %h", i, dig_en, seg_n, e_dig, e_seg);
      end
    end
  endtask

  task automatic test_load_1234();
    logic [7:0] want [4] = '{8'hF9, 8'hA4, 8'h30, 8'h99};
    drive_load(16'd1234, 4'b0100);
    for (int k = 0; k < 18; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (load_ready !== (k == 17)) begin
        failures++;
        $display("FAIL latency edge N+%0d: load_ready=%b want %b", k, load_ready, k == 17);
      end
    end
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (k > 0 && dig_en !== 4'd0) begin
        checks++;
        if ($countones(dig_en) != 1 || seg_n !== want[$clog2(dig_en)]) begin
          failures++;
          $display("FAIL digits_1234: dig_en=%b seg_n=%h", dig_en, seg_n);
        end
      end
    end
  endtask

  task automatic test_dash();
    logic [15:0] vals [2] = '{16'd10000, 16'd9999};
    logic [7:0] segs [2] = '{8'hBF, 8'h90};
    for (int j = 0; j < 2; j++) begin
      drive_load(vals[j], j == 0 ? 4'hF : 4'h0);
      for (int k = 0; k < 45; k++) begin
        @(negedge clk); checks++;
        if ({dig_en, seg_n, load_ready} !== {e_dig, e_seg, e_ready}) begin
          failures++;
          $display("FAIL dash_model %0d: dig=%b seg=%h rdy=%b want %b %h %b", vals[j], dig_en, seg_n, load_ready, e_dig, e_seg, e_ready);
        end
`ifndef LEADING_ZERO_BLANK_EN
        if (k >= 20 && dig_en !== 4'd0) begin
          checks++;
          if (seg_n !== segs[j]) begin
            failures++;
            $display("FAIL dash_const %0d: seg_n=%h want %h", vals[j], seg_n, segs[j]);
          end
        end
`endif
      end
    end
  endtask

  task automatic test_back_to_back();
    load_valid = 1;
    for (int k = 0; k < 60; k++) begin
      value = 16'($urandom_range(0, 9999)); dp_mask = 4'($urandom);
      @(negedge clk); checks++;
      if ({dig_en, seg_n, load_ready} !== {e_dig, e_seg, e_ready}) begin
        failures++;
        $display("FAIL back_to_back cyc %0d: dig=%b seg=%h rdy=%b want %b %h %b", k, dig_en, seg_n, load_ready, e_dig, e_seg, e_ready);
      end
    end
    load_valid = 0;
  endtask

  task automatic test_reset_mid_convert();
    drive_load(16'd4321, 4'b1010);
    repeat (7) @(negedge clk);
    rst = 1;
    repeat (2) begin
      @(negedge clk); checks++;
      if (dig_en !== 4'd0 || seg_n !== 8'hFF || load_ready !== 1'b0) begin
        failures++;
        $display("FAIL abort_reset: dig_en=%b seg_n=%h ready=%b want 0000 ff 0", dig_en, seg_n, load_ready);
      end
    end
    rst = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); checks++;
      if ({dig_en, seg_n, load_ready} !== {e_dig, e_seg, e_ready}) begin
        failures++;
        $display("FAIL abort_display cyc %0d: dig=%b seg=%h rdy=%b want %b %h %b", k, dig_en, seg_n, load_ready, e_dig, e_seg, e_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] vals [8] = '{16'd7, 16'd0, 16'($urandom_range(0, 99)), 16'($urandom_range(100, 999)),
                              16'($urandom_range(1000, 9999)), 16'($urandom_range(10000, 65535)),
                              16'($urandom_range(0, 9999)), 16'd65535};
    for (int j = 0; j < 8; j++) begin
      drive_load(vals[j], 4'($urandom));
      for (int k = 0; k < 45; k++) begin
        @(negedge clk); checks++;
        if ({dig_en, seg_n, load_ready} !== {e_dig, e_seg, e_ready}) begin
          failures++;
          $display("FAIL random %0d cyc %0d: dig=%b seg=%h rdy=%b want %b %h %b", vals[j], k, dig_en, seg_n, load_ready, e_dig, e_seg, e_ready);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_1234();
    test_dash();
    test_back_to_back();
    test_reset_mid_convert();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
